// File: rtl/bcd_to_bin.sv
// Sequential 5-digit packed-BCD to 16-bit binary converter (reverse double-dabble).
// One shift per clock with per-digit subtract-3 correction; start/busy/done handshake.
module bcd_to_bin #(
    parameter int DIGITS = 5,
    parameter int OUT_W  = 16,
    parameter int ITER   = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [OUT_W-1:0]      bin_out,
    output logic                  ovf,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [ITER-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                errp_q, errp_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [OUT_W-1:0]    bin_q, bin_d;
    logic                ovf_q, ovf_d;
    logic                err_q, err_d;

    logic [BCD_W-1:0]    shift_bcd;
    logic [ITER-1:0]     shift_acc;

    // A digit is >= 8 exactly when its MSB is set, so only bit 3 gates the correction.
    function automatic logic [BCD_W-1:0] adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i+3]) begin
                r[4*i +: 4] = v[4*i +: 4] - 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic any_illegal(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | (v[4*i+3] & (v[4*i+2] | v[4*i+1]));
        end
        return bad;
    endfunction

    assign {shift_bcd, shift_acc} = {bcd_q, acc_q} >> 1;

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        errp_d  = errp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bin_d   = bin_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = LOAD;
                    if (any_illegal(bcd_in)) begin
                        errp_d = 1'b1;
                    end else begin
                        errp_d = 1'b0;
                        bcd_d  = bcd_in;
                    end
                end
            end
            LOAD: begin
                // An illegal request passes through here for one cycle so its latency is fixed at 2.
                if (errp_q) begin
                    state_d = FIN;
                end else begin
                    bcd_d   = adjust(shift_bcd);
                    acc_d   = shift_acc;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = adjust(shift_bcd);
                acc_d = shift_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                errp_d  = 1'b0;
                if (errp_q) begin
                    bin_d = '0;
                    ovf_d = 1'b0;
                    err_d = 1'b1;
                end else begin
                    bin_d = acc_q[OUT_W-1:0];
                    ovf_d = |acc_q[ITER-1:OUT_W];
                    err_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            errp_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            errp_q  <= errp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bin_out = bin_q;
    assign ovf     = ovf_q;
    assign err     = err_q;

endmodule
